result_reader: RTL and testbench
================================

RESULT_READER -- requirements
Module: result_reader

Interface
REQ-001 Parameter AW, default 8: result-memory address width.
REQ-002 Parameter DW, default 8: result data width.
REQ-003 Parameter MEM_LAT, default 1, legal range 1..4: cycles from mem_re to valid mem_rdata.
REQ-004 Port clk  input  1  the only clock; all state SHALL change on its rising edge.
REQ-005 Port rst_n  input  1  reset, asynchronous, active-low.
REQ-006 Port start  input  1  begin a readout burst.
REQ-007 Port base_addr  input  AW  first result address, sampled with start.
REQ-008 Port count  input  AW  number of words to read, sampled with start.
REQ-009 Port mem_re  output  1  result-memory read enable.
REQ-010 Port mem_addr  output  AW  result-memory read address.
REQ-011 Port mem_rdata  input  DW  result-memory read data.
REQ-012 Port out_data  output  DW  streamed result word.
REQ-013 Port out_valid  output  1  out_data valid.
REQ-014 Port out_ready  input  1  sink accepts out_data.
REQ-015 Port busy  output  1  high from accepted start until done.
REQ-016 Port done  output  1  one-cycle pulse at burst end.
REQ-017 Port checksum  output  DW  present only with RESULT_READER_CKSUM_EN.

Function
REQ-018 FSM states SHALL be IDLE, RD, WAIT, OUT, FIN.
REQ-019 IDLE: start=1 with count!=0 SHALL latch base_addr and count and go to RD; with count=0 SHALL go to FIN.
REQ-020 start while busy=1 SHALL be ignored.
REQ-021 RD: mem_re=1 for exactly one cycle, mem_addr=current address; then WAIT.
REQ-022 WAIT: lasts MEM_LAT cycles; on its last cycle mem_rdata SHALL be captured into out_data; then OUT.
REQ-023 OUT: out_valid=1 and out_data held stable until out_ready=1; a transfer occurs on the edge where both are 1.
REQ-024 After a transfer, the address SHALL increment modulo 2^AW (0xFF wraps to 0x00) and the remaining count SHALL decrement; if the count reaches 0, go to FIN, else go to RD.
REQ-025 FIN: done=1 for one cycle, busy=0 in the following cycle, return to IDLE.
REQ-026 Timing with MEM_LAT=1: start sampled at edge 0; mem_re high during cycle 1; out_valid high from cycle 3.
REQ-027 Minimum period SHALL be MEM_LAT+2 cycles per word when out_ready=1.
REQ-028 mem_addr SHALL hold its last value outside RD; mem_re=0 outside RD.

Reset
REQ-029 rst_n=0 SHALL immediately force IDLE, with mem_re=0, mem_addr=0, out_data=0, out_valid=0, busy=0, done=0, checksum=0.
REQ-030 Reset mid-burst SHALL abandon the burst; no done pulse follows.

Configuration
REQ-031 With RESULT_READER_CKSUM_EN defined: checksum SHALL clear on an accepted start and add each transferred word modulo 2^DW; it SHALL be final when done=1 and hold until the next start.
REQ-032 Without RESULT_READER_CKSUM_EN: the checksum port and its logic SHALL be absent; all other behaviour is identical.

Structure
REQ-033 Package result_pkg SHALL hold the FSM state enum, default AW/DW, and the MEM_LAT bounds.
REQ-034 Sub-module result_cksum (accumulator) SHALL be instantiated only under RESULT_READER_CKSUM_EN.

Verification
REQ-035 Memory[5..7]={0x32,0x11,0x07}, base=5, count=3, out_ready=1 -> out_data 0x32,0x11,0x07 in order, done once, checksum=0x4A.
REQ-036 base=0xFE, count=3 -> mem_addr sequence 0xFE,0xFF,0x00.
REQ-037 out_ready=0 for 10 cycles during OUT -> out_valid and out_data stable; no new mem_re.
REQ-038 count=0 -> done pulse within 2 cycles, mem_re never asserted.
REQ-039 start pulsed again mid-burst -> ignored; burst completes with the original count.
REQ-040 rst_n=0 mid-WAIT -> all outputs 0 asynchronously; the next start runs normally.

Source files
------------

// File: rtl/result_pkg.sv
// Shared types and defaults for the result readout block: FSM state encoding,
// default address/data widths and the supported memory read-latency range.
package result_pkg;

   localparam int AW_DEF      = 8;
   localparam int DW_DEF      = 8;
   localparam int MEM_LAT_MIN = 1;
   localparam int MEM_LAT_MAX = 4;

   typedef enum logic [2:0] {
      IDLE,
      RD,
      WAIT,
      OUT,
      FIN
   } state_t;

endpackage

// File: rtl/result_cksum.sv
// Running modulo-2^DW sum of the words streamed out of result_reader.
// Cleared when a burst is accepted; only built with RESULT_READER_CKSUM_EN.
module result_cksum #(
   parameter int DW = 8
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          clear,
   input  logic          add,
   input  logic [DW-1:0] data,
   output logic [DW-1:0] sum
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         sum <= '0;
      else if (clear)
         sum <= '0;
      else if (add)
         sum <= sum + data;
   end

endmodule

// File: rtl/result_reader.sv
// Reads count words from a result memory starting at base_addr and streams them
// out over a valid/ready port. Optional checksum output: RESULT_READER_CKSUM_EN.
// MEM_LAT must lie in result_pkg::MEM_LAT_MIN..MEM_LAT_MAX.
module result_reader
   import result_pkg::*;
#(
   parameter int AW      = AW_DEF,
   parameter int DW      = DW_DEF,
   parameter int MEM_LAT = 1
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          start,
   input  logic [AW-1:0] base_addr,
   input  logic [AW-1:0] count,
   output logic          mem_re,
   output logic [AW-1:0] mem_addr,
   input  logic [DW-1:0] mem_rdata,
   output logic [DW-1:0] out_data,
   output logic          out_valid,
   input  logic          out_ready,
   output logic          busy,
   output logic          done
`ifdef RESULT_READER_CKSUM_EN
   ,
   output logic [DW-1:0] checksum
`endif
);

   state_t        state, state_nxt;
   logic [AW-1:0] rem;
   logic [2:0]    lat_cnt;
   logic          accept;
   logic          xfer;
   logic          last_lat;

   assign accept   = (state == IDLE) && start;
   assign xfer     = (state == OUT) && out_ready;
   assign last_lat = (lat_cnt == 3'(MEM_LAT - 1));

   assign mem_re    = (state == RD);
   assign out_valid = (state == OUT);
   assign busy      = (state != IDLE);
   assign done      = (state == FIN);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   always_comb begin
      // NOTE: default first so every path assigns state_nxt and no latch is inferred.
      state_nxt = state;
      case (state)
         IDLE:    if (start) state_nxt = (count != '0) ? RD : FIN;
         RD:      state_nxt = WAIT;
         WAIT:    if (last_lat) state_nxt = OUT;
         OUT:     if (out_ready) state_nxt = (rem == AW'(1)) ? FIN : RD;
         FIN:     state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // mem_addr doubles as the current address; it only moves when another read
   // will follow, so it holds its last value outside RD.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         // NOTE: non-blocking assignments keep all registers updating from pre-edge values.
         mem_addr <= '0;
         rem      <= '0;
         lat_cnt  <= '0;
         out_data <= '0;
      end else begin
         if (accept && count != '0) begin
            mem_addr <= base_addr;
            rem      <= count;
         end
         if (state == RD)
            lat_cnt <= '0;
         if (state == WAIT) begin
            lat_cnt <= lat_cnt + 3'd1;
            if (last_lat)
               out_data <= mem_rdata;
         end
         if (xfer) begin
            rem <= rem - AW'(1);
            if (rem != AW'(1))
               mem_addr <= mem_addr + AW'(1);
         end
      end
   end

`ifdef RESULT_READER_CKSUM_EN
   result_cksum #(.DW(DW)) u_cksum (
      .clk   (clk),
      .rst_n (rst_n),
      .clear (accept),
      .add   (xfer),
      .data  (out_data),
      .sum   (checksum)
   );
`endif

endmodule

// File: tb/tb_result_reader.sv
// Directed self-checking bench for result_reader (MEM_LAT=1, 8-bit widths).
// Checksum comparisons are compiled in with RESULT_READER_CKSUM_EN.
module tb_result_reader;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       start;
   logic [7:0] base_addr;
   logic [7:0] count;
   logic       mem_re;
   logic [7:0] mem_addr;
   logic [7:0] mem_rdata = '0;
   logic [7:0] out_data;
   logic       out_valid;
   logic       out_ready;
   logic       busy;
   logic       done;
`ifdef RESULT_READER_CKSUM_EN
   logic [7:0] checksum;
`endif

   result_reader #(.AW(8), .DW(8), .MEM_LAT(1)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .base_addr (base_addr),
      .count     (count),
      .mem_re    (mem_re),
      .mem_addr  (mem_addr),
      .mem_rdata (mem_rdata),
      .out_data  (out_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .busy      (busy),
      .done      (done)
`ifdef RESULT_READER_CKSUM_EN
      ,
      .checksum  (checksum)
`endif
   );

   always #5 clk = ~clk;

   // Result memory with one cycle of read latency.
   logic [7:0] mem [256];
   always @(posedge clk) if (mem_re) mem_rdata <= mem[mem_addr];

   // Monitor, sampled on the falling edge.
   logic [7:0] data_q[$];
   logic [7:0] addr_q[$];
   int re_cnt   = 0;
   int done_cnt = 0;
   always @(negedge clk) begin
      if (rst_n === 1'b1) begin
         if (mem_re) begin
            addr_q.push_back(mem_addr);
            re_cnt++;
         end
         if (out_valid && out_ready) data_q.push_back(out_data);
         if (done) done_cnt++;
      end
   end

   int n_cmp = 0;
   int n_err = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic check_seq(input string tag, input logic [7:0] got[$], input logic [7:0] exp[$]);
      check({tag, "_len"}, got.size(), exp.size());
      for (int i = 0; i < exp.size(); i++)
         if (i < got.size()) check($sformatf("%s[%0d]", tag, i), got[i], exp[i]);
   endtask

   task automatic pulse_start(input logic [7:0] b, input logic [7:0] c);
      @(posedge clk) #1;
      start = 1'b1; base_addr = b; count = c;
      @(posedge clk) #1;
      start = 1'b0;
   endtask

   task automatic wait_done(input string tag, input int budget);
      bit seen = 1'b0;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         if (done) begin
            seen = 1'b1;
            break;
         end
      end
      check({tag, "_done_seen"}, seen, 1);
      if (seen) begin
         @(negedge clk);
         check({tag, "_busy_after"}, busy, 0);
         check({tag, "_done_1cyc"}, done, 0);
      end
   endtask

   task automatic clear_mon();
      data_q.delete();
      addr_q.delete();
      re_cnt   = 0;
      done_cnt = 0;
   endtask

   initial begin
      int re_before;
      int done_before;
      rst_n = 1'b0; start = 1'b0; base_addr = '0; count = '0; out_ready = 1'b1;
      for (int i = 0; i < 256; i++) mem[i] = 8'(i) ^ 8'h5A;
      mem[5] = 8'h32; mem[6] = 8'h11; mem[7] = 8'h07;
      mem[8'hFE] = 8'hA1; mem[8'hFF] = 8'hB2; mem[8'h00] = 8'hC3;

      // Reset state
      #12;
      check("rst_mem_re", mem_re, 0);
      check("rst_mem_addr", mem_addr, 0);
      check("rst_out_data", out_data, 0);
      check("rst_out_valid", out_valid, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
`ifdef RESULT_READER_CKSUM_EN
      check("rst_cksum", checksum, 0);
`endif
      @(posedge clk) #1 rst_n = 1'b1;

      // Basic burst with cycle-accurate first-word timing
      clear_mon();
      pulse_start(8'd5, 8'd3);
      @(negedge clk);
      check("t1_c1_mem_re", mem_re, 1);
      check("t1_c1_mem_addr", mem_addr, 5);
      check("t1_c1_busy", busy, 1);
      @(negedge clk);
      check("t1_c2_mem_re", mem_re, 0);
      check("t1_c2_out_valid", out_valid, 0);
      @(negedge clk);
      check("t1_c3_out_valid", out_valid, 1);
      check("t1_c3_out_data", out_data, 8'h32);
      wait_done("t1", 20);
      check_seq("t1_data", data_q, '{8'h32, 8'h11, 8'h07});
      check("t1_done_cnt", done_cnt, 1);
      check("t1_re_cnt", re_cnt, 3);
      check("t1_addr_hold", mem_addr, 7);
`ifdef RESULT_READER_CKSUM_EN
      check("t1_cksum", checksum, 8'h4A);
`endif

      // Address wrap
      clear_mon();
      pulse_start(8'hFE, 8'd3);
      wait_done("t2", 20);
      check_seq("t2_addr", addr_q, '{8'hFE, 8'hFF, 8'h00});
      check_seq("t2_data", data_q, '{8'hA1, 8'hB2, 8'hC3});

      // Sink stall for 10 cycles
      clear_mon();
      out_ready = 1'b0;
      pulse_start(8'd5, 8'd2);
      for (int i = 0; i < 10; i++) begin
         if (out_valid) break;
         @(negedge clk);
      end
      check("t3_valid_seen", out_valid, 1);
      re_before = re_cnt;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         check($sformatf("t3_hold_valid%0d", i), out_valid, 1);
         check($sformatf("t3_hold_data%0d", i), out_data, 8'h32);
      end
      check("t3_no_new_re", re_cnt, re_before);
      out_ready = 1'b1;
      wait_done("t3", 20);
      check_seq("t3_data", data_q, '{8'h32, 8'h11});

      // count = 0
      clear_mon();
      pulse_start(8'd9, 8'd0);
      wait_done("t4", 2);
      check("t4_re_cnt", re_cnt, 0);
`ifdef RESULT_READER_CKSUM_EN
      check("t4_cksum", checksum, 0);
`endif

      // start while busy is ignored
      clear_mon();
      pulse_start(8'd5, 8'd3);
      @(posedge clk) #1;
      @(posedge clk) #1;
      start = 1'b1; base_addr = 8'd0; count = 8'd1;
      @(posedge clk) #1;
      start = 1'b0;
      wait_done("t5", 20);
      check_seq("t5_addr", addr_q, '{8'd5, 8'd6, 8'd7});
      check("t5_done_cnt", done_cnt, 1);

      // Reset during WAIT, then a normal burst
      clear_mon();
      pulse_start(8'd5, 8'd3);
      @(posedge clk) #3;
      rst_n = 1'b0;
      #1;
      check("t6_rst_mem_re", mem_re, 0);
      check("t6_rst_mem_addr", mem_addr, 0);
      check("t6_rst_out_data", out_data, 0);
      check("t6_rst_out_valid", out_valid, 0);
      check("t6_rst_busy", busy, 0);
      check("t6_rst_done", done, 0);
`ifdef RESULT_READER_CKSUM_EN
      check("t6_rst_cksum", checksum, 0);
`endif
      @(posedge clk) #1 rst_n = 1'b1;
      done_before = done_cnt;
      repeat (5) @(negedge clk);
      check("t6_no_done", done_cnt, done_before);
      check("t6_idle_busy", busy, 0);
      clear_mon();
      pulse_start(8'd5, 8'd3);
      wait_done("t6", 20);
      check_seq("t6_data", data_q, '{8'h32, 8'h11, 8'h07});
`ifdef RESULT_READER_CKSUM_EN
      check("t6_cksum", checksum, 8'h4A);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
